// File: rtl/key_off_cfg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : key_off_cfg_sched
//  Purpose  : Queues key-extract offset RAM writes and issues each one as a
//             single-cycle strobe in a PHV gap on the target stage. The
//             optional KEY_OFF_SHADOW_EN build adds a readable shadow copy.
//  Revision : 1.0  initial release
// ============================================================================
module key_off_cfg_sched #(
    parameter int NUM_STAGES = 5,
    parameter int KEY_OFF    = 18,
    parameter int AXIL_WIDTH = 32,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_stage,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [KEY_OFF-1:0]    cfg_data,
    input  logic [NUM_STAGES-1:0] stage_busy,
`ifdef KEY_OFF_SHADOW_EN
    input  logic                  rd_req,
    input  logic [2:0]            rd_stage,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_valid,
    output logic [KEY_OFF-1:0]    rd_data,
`endif
    output logic [AXIL_WIDTH-1:0] key_off_entry_out,
    output logic [ADDR_W-1:0]     key_off_entry_addr,
    output logic [NUM_STAGES-1:0] key_off_entry_valid,
    output logic                  cfg_done,
    output logic                  cfg_err
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FIFO_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       STARVE_LAST = 8'(STARVE_MAX - 1);
    localparam logic [0:0]       ST_IDLE     = 1'b0;
    localparam logic [0:0]       ST_WAIT     = 1'b1;

    typedef struct packed {
        logic [2:0]         stage;
        logic [ADDR_W-1:0]  addr;
        logic [KEY_OFF-1:0] data;
    } req_t;

    req_t                  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;
    logic [0:0]            state_q, state_d;
    logic [7:0]            starve_cnt_q, starve_cnt_d;
    req_t                  hold_q, hold_d;
    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [KEY_OFF-1:0]    data_q, data_d;
    logic                  done_q, done_d, err_q, err_d;
    logic                  push, pop;
    req_t                  head;
    logic [NUM_STAGES-1:0] hold_onehot;
    logic                  hold_busy;

    assign push        = cfg_valid & ready_q;
    assign head        = fifo_mem[rd_ptr_q];
    assign hold_onehot = NUM_STAGES'(1) << hold_q.stage;
    assign hold_busy   = |(stage_busy & hold_onehot);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        hold_d       = hold_q;
        pop          = 1'b0;
        valid_d      = '0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop          = 1'b1;
                    hold_d       = head;
                    starve_cnt_d = '0;
                    // Out-of-range stages are dropped here and never reach WAIT
                    if (32'(head.stage) >= 32'(NUM_STAGES)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!hold_busy || starve_cnt_q == STARVE_LAST) begin
                    valid_d = hold_onehot;
                    addr_d  = hold_q.addr;
                    data_d  = hold_q.data;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    starve_cnt_d = starve_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ready_d  = (count_d != FIFO_FULL);
    end

    // Queue storage carries no reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{stage: cfg_stage, addr: cfg_addr, data: cfg_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
            hold_q       <= '0;
            valid_q      <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            hold_q       <= hold_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign cfg_ready           = ready_q;
    assign key_off_entry_out   = {{(AXIL_WIDTH-KEY_OFF){1'b0}}, data_q};
    assign key_off_entry_addr  = addr_q;
    assign key_off_entry_valid = valid_q;
    assign cfg_done            = done_q;
    assign cfg_err             = err_q;

`ifdef KEY_OFF_SHADOW_EN
    localparam int DEPTH = 1 << ADDR_W;

    logic [KEY_OFF-1:0] shadow_rd [NUM_STAGES];
    logic               rd_valid_q, rd_valid_d;
    logic [KEY_OFF-1:0] rd_data_q, rd_data_d;

    genvar gs;
    generate
        for (gs = 0; gs < NUM_STAGES; gs++) begin : g_shadow
            logic [KEY_OFF-1:0] mem_q [DEPTH];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
                end else if (valid_d[gs]) begin
                    mem_q[addr_d] <= data_d;
                end
            end
            assign shadow_rd[gs] = mem_q[rd_addr];
        end
    endgenerate

    // Read samples pre-write contents, so a same-cycle write returns old data
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        if (rd_req) begin
            rd_data_d = '0;
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (32'(rd_stage) == 32'(s)) rd_data_d = shadow_rd[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_off_cfg_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_off_cfg_sched
//  Purpose  : Directed self-checking bench for key_off_cfg_sched; the shadow
//             read checks are built only with KEY_OFF_SHADOW_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_off_cfg_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_stage;
    logic [3:0]  cfg_addr;
    logic [17:0] cfg_data;
    logic [4:0]  stage_busy;
    logic [31:0] key_off_entry_out;
    logic [3:0]  key_off_entry_addr;
    logic [4:0]  key_off_entry_valid;
    logic        cfg_done;
    logic        cfg_err;
`ifdef KEY_OFF_SHADOW_EN
    logic        rd_req;
    logic [2:0]  rd_stage;
    logic [3:0]  rd_addr;
    logic        rd_valid;
    logic [17:0] rd_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    key_off_cfg_sched dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cfg_valid           (cfg_valid),
        .cfg_ready           (cfg_ready),
        .cfg_stage           (cfg_stage),
        .cfg_addr            (cfg_addr),
        .cfg_data            (cfg_data),
        .stage_busy          (stage_busy),
`ifdef KEY_OFF_SHADOW_EN
        .rd_req              (rd_req),
        .rd_stage            (rd_stage),
        .rd_addr             (rd_addr),
        .rd_valid            (rd_valid),
        .rd_data             (rd_data),
`endif
        .key_off_entry_out   (key_off_entry_out),
        .key_off_entry_addr  (key_off_entry_addr),
        .key_off_entry_valid (key_off_entry_valid),
        .cfg_done            (cfg_done),
        .cfg_err             (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] s, input logic [3:0] a, input logic [17:0] d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_stage = s;
        cfg_addr  = a;
        cfg_data  = d;
        while (!cfg_ready && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("push_timeout", 32'(n), 32'd0);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (key_off_entry_valid == '0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check("strobe_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int          n;
        logic        early;
        int          stale;
        logic [17:0] d3 [5];

        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_stage  = '0;
        cfg_addr   = '0;
        cfg_data   = '0;
        stage_busy = '0;
`ifdef KEY_OFF_SHADOW_EN
        rd_req   = 1'b0;
        rd_stage = '0;
        rd_addr  = '0;
`endif
        tick();
        tick();
        check("rst_ready", 32'(cfg_ready), 32'd0);
        check("rst_valid", 32'(key_off_entry_valid), 32'd0);
        check("rst_out",   key_off_entry_out, 32'd0);
        check("rst_done",  32'(cfg_done), 32'd0);
        check("rst_err",   32'(cfg_err), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(cfg_ready), 32'd1);

        // Idle stage: strobe at t+3 for exactly one cycle
        push(3'd2, 4'd5, 18'h2A5A5);
        tick();
        check("t1_no_early", 32'(key_off_entry_valid), 32'd0);
        tick();
        check("t1_valid", 32'(key_off_entry_valid), 32'h04);
        check("t1_addr",  32'(key_off_entry_addr), 32'd5);
        check("t1_out",   key_off_entry_out, 32'h0002A5A5);
        check("t1_done",  32'(cfg_done), 32'd1);
        tick();
        check("t1_valid_off", 32'(key_off_entry_valid), 32'd0);
        check("t1_done_off",  32'(cfg_done), 32'd0);
        check("t1_addr_hold", 32'(key_off_entry_addr), 32'd5);

        // Busy for 10 cycles, then the strobe fires the cycle after it drops
        stage_busy = 5'b00010;
        push(3'd1, 4'd7, 18'h3FFFF);
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (key_off_entry_valid != '0) early = 1'b1;
            tick();
        end
        check("t2_held_off", 32'(early), 32'd0);
        stage_busy = 5'b00000;
        check("t2_not_same_cycle", 32'(key_off_entry_valid), 32'd0);
        tick();
        check("t2_valid", 32'(key_off_entry_valid), 32'h02);
        check("t2_out",   key_off_entry_out, 32'h0003FFFF);
        check("t2_addr",  32'(key_off_entry_addr), 32'd7);
        tick();

        // Busy forever: forced at WAIT cycle 64, strobe 66 cycles after accept
        stage_busy = 5'b11111;
        push(3'd3, 4'd1, 18'h00011);
        n = 0;
        while (key_off_entry_valid == '0 && n < 300) begin
            tick();
            n++;
        end
        check("t2_starve_lat", 32'(n), 32'd65);
        check("t2_starve_valid", 32'(key_off_entry_valid), 32'h08);
        tick();

        // Five back-to-back requests, all stages busy
        for (int i = 0; i < 5; i++) d3[i] = 18'h10000 + 18'(i * 18'h111);
        for (int i = 0; i < 5; i++) begin
            check("t3_ready_b2b", 32'(cfg_ready), 32'd1);
            cfg_valid = 1'b1;
            cfg_stage = 3'(i);
            cfg_addr  = 4'(i + 8);
            cfg_data  = d3[i];
            tick();
        end
        cfg_valid = 1'b0;
        check("t3_ready_full", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_strobe();
            check("t3_order_valid", 32'(key_off_entry_valid), 32'(5'b00001 << i));
            check("t3_order_addr",  32'(key_off_entry_addr), 32'(i + 8));
            check("t3_order_out",   key_off_entry_out, 32'(d3[i]));
            check("t3_done",        32'(cfg_done), 32'd1);
            tick();
        end
        check("t3_ready_drained", 32'(cfg_ready), 32'd1);

        // Bad stage dropped with cfg_err; following request still issues
        stage_busy = 5'b00000;
        push(3'd7, 4'd9, 18'h0ABCD);
        push(3'd4, 4'd2, 18'h15555);
        check("t4_err",      32'(cfg_err), 32'd1);
        check("t4_no_valid", 32'(key_off_entry_valid), 32'd0);
        tick();
        check("t4_err_off",  32'(cfg_err), 32'd0);
        tick();
        check("t4_valid", 32'(key_off_entry_valid), 32'h10);
        check("t4_addr",  32'(key_off_entry_addr), 32'd2);
        check("t4_out",   key_off_entry_out, 32'h00015555);
        tick();

        // Reset in WAIT with three queued requests
        stage_busy = 5'b11111;
        push(3'd0, 4'd1, 18'h00001);
        push(3'd1, 4'd2, 18'h00002);
        push(3'd2, 4'd3, 18'h00003);
        push(3'd3, 4'd4, 18'h00004);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_ready", 32'(cfg_ready), 32'd0);
        check("t5_out",   key_off_entry_out, 32'd0);
        check("t5_addr",  32'(key_off_entry_addr), 32'd0);
        check("t5_valid", 32'(key_off_entry_valid), 32'd0);
        tick();
        tick();
        rst_n      = 1'b1;
        stage_busy = 5'b00000;
        stale = 0;
        for (int i = 0; i < 100; i++) begin
            if (key_off_entry_valid != '0 || cfg_done || cfg_err) stale++;
            tick();
        end
        check("t5_no_stale", 32'(stale), 32'd0);
        check("t5_ready_back", 32'(cfg_ready), 32'd1);

`ifdef KEY_OFF_SHADOW_EN
        push(3'd0, 4'd3, 18'h01234);
        wait_strobe();
        tick();
        rd_req   = 1'b1;
        rd_stage = 3'd0;
        rd_addr  = 4'd3;
        tick();
        check("t6_rd_valid", 32'(rd_valid), 32'd1);
        check("t6_rd_data",  32'(rd_data), 32'h01234);
        rd_addr = 4'd4;
        tick();
        check("t6_rd_empty", 32'(rd_data), 32'd0);
        rd_req = 1'b0;
        tick();
        check("t6_rd_valid_off", 32'(rd_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
